// File: rtl/vector_exec_pipe.sv
// Two-stage vector ALU: S1 registers the accepted operation, S2 holds per-lane results.
// Ready/valid on both sides; a full pipe with a stalled consumer back-pressures the producer.
module vector_exec_pipe #(
  parameter int DATA_WIDTH  = 19,
  parameter int FRAC_WIDTH  = 11,
  parameter int VECTOR_SIZE = 6
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              inValid,
  output logic                              inReady,
  input  logic [2:0]                        aluControl,
  input  logic [VECTOR_SIZE*DATA_WIDTH-1:0] operand1,
  input  logic [VECTOR_SIZE*DATA_WIDTH-1:0] operand2,
  input  logic [DATA_WIDTH-1:0]             scalarOperand,
  input  logic                              useScalar,
  input  logic [VECTOR_SIZE-1:0]            vectorMask,
  input  logic                              saturate,
  output logic                              outValid,
  input  logic                              outReady,
  output logic [VECTOR_SIZE*DATA_WIDTH-1:0] result,
  output logic [VECTOR_SIZE-1:0]            compareMask,
  output logic [VECTOR_SIZE-1:0]            overflow
);

  localparam int W  = DATA_WIDTH;
  localparam int VW = VECTOR_SIZE * DATA_WIDTH;

  localparam logic signed [2*W-1:0] MAX_X = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W-1:0] MIN_X = {{(W+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic [W-1:0]          MAX_W = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]          MIN_W = {1'b1, {(W-1){1'b0}}};

  typedef struct packed {
    logic [W-1:0] res;
    logic         cmp;
    logic         ovf;
  } lane_t;

  // Arithmetic is done at 2*W bits so the exact add/sub/mul value is available for the range check.
  function automatic lane_t lane_op(input logic [2:0] op, input logic [W-1:0] a,
                                    input logic [W-1:0] b, input logic sat, input logic en);
    logic signed [2*W-1:0] ae, be, prod, exact;
    logic arith;
    lane_t r;
    ae    = {{W{a[W-1]}}, a};
    be    = {{W{b[W-1]}}, b};
    prod  = ae * be;
    exact = '0;
    arith = 1'b0;
    r.res = a;
    r.cmp = 1'b0;
    r.ovf = 1'b0;
    case (op)
      3'b000: begin exact = ae + be; arith = 1'b1; end
      3'b001: begin exact = ae - be; arith = 1'b1; end
      3'b010: begin exact = prod >>> FRAC_WIDTH; arith = 1'b1; end
      3'b011: r.res = a & b;
      3'b100: r.res = a | b;
      3'b101: r.res = a ^ b;
      3'b110: r.cmp = $signed(a) < $signed(b);
      default: r.res = b;
    endcase
    if (arith) begin
      r.ovf = (exact > MAX_X) || (exact < MIN_X);
      if (r.ovf && sat) r.res = exact[2*W-1] ? MIN_W : MAX_W;
      else              r.res = exact[W-1:0];
    end
    if (!en) begin
      r.res = a;
      r.cmp = 1'b0;
      r.ovf = 1'b0;
    end
    return r;
  endfunction

  logic                   v1_q, v1_d, v2_q, v2_d;
  logic [2:0]             ctrl_q;
  logic [VW-1:0]          op1_q, op2_q;
  logic [VECTOR_SIZE-1:0] mask_q;
  logic                   sat_q;
  logic [VW-1:0]          res_q, res_d;
  logic [VECTOR_SIZE-1:0] cmp_q, cmp_d, ovf_q, ovf_d;
  logic [VW-1:0]          op2_sel;
  logic                   in_fire, adv1;

  assign inReady = !v1_q || !v2_q || outReady;
  assign in_fire = inValid && inReady;
  assign adv1    = !v2_q || outReady;
  assign op2_sel = useScalar ? {VECTOR_SIZE{scalarOperand}} : operand2;

  // S1 empties into S2 whenever S2 has room, so accept and drain on one edge never collide.
  always_comb begin
    v1_d = v1_q;
    if (in_fire)   v1_d = 1'b1;
    else if (adv1) v1_d = 1'b0;
    v2_d = adv1 ? v1_q : v2_q;
  end

  lane_t lane_w [VECTOR_SIZE];

  for (genvar i = 0; i < VECTOR_SIZE; i++) begin : g_lane
    assign lane_w[i] = lane_op(ctrl_q, op1_q[i*W +: W], op2_q[i*W +: W], sat_q, mask_q[i]);
    assign res_d[i*W +: W] = lane_w[i].res;
    assign cmp_d[i]        = lane_w[i].cmp;
    assign ovf_d[i]        = lane_w[i].ovf;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      ctrl_q <= '0;
      op1_q  <= '0;
      op2_q  <= '0;
      mask_q <= '0;
      sat_q  <= 1'b0;
      res_q  <= '0;
      cmp_q  <= '0;
      ovf_q  <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      if (in_fire) begin
        ctrl_q <= aluControl;
        op1_q  <= operand1;
        op2_q  <= op2_sel;
        mask_q <= vectorMask;
        sat_q  <= saturate;
      end
      if (adv1 && v1_q) begin
        res_q <= res_d;
        cmp_q <= cmp_d;
        ovf_q <= ovf_d;
      end
    end
  end

  assign outValid    = v2_q;
  assign result      = res_q;
  assign compareMask = cmp_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_vector_exec_pipe.sv
// Directed bench for vector_exec_pipe: arithmetic corners, masking, back-pressure, and reset flush.
module tb_vector_exec_pipe;

  localparam int DW = 19;
  localparam int FW = 11;
  localparam int VS = 6;
  localparam int VW = DW * VS;

  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_MUL = 3'b010, OP_AND = 3'b011,
                         OP_OR  = 3'b100, OP_XOR = 3'b101, OP_LT  = 3'b110, OP_PASS = 3'b111;

  logic          clock = 1'b0;
  logic          reset;
  logic          inValid, inReady, useScalar, saturate, outValid, outReady;
  logic [2:0]    aluControl;
  logic [VW-1:0] operand1, operand2, result;
  logic [DW-1:0] scalarOperand;
  logic [VS-1:0] vectorMask, compareMask, overflow;

  int checks   = 0;
  int failures = 0;

  vector_exec_pipe #(.DATA_WIDTH(DW), .FRAC_WIDTH(FW), .VECTOR_SIZE(VS)) dut (
    .clock(clock), .reset(reset), .inValid(inValid), .inReady(inReady),
    .aluControl(aluControl), .operand1(operand1), .operand2(operand2),
    .scalarOperand(scalarOperand), .useScalar(useScalar), .vectorMask(vectorMask),
    .saturate(saturate), .outValid(outValid), .outReady(outReady), .result(result),
    .compareMask(compareMask), .overflow(overflow)
  );

  always #5 clock = ~clock;

  function automatic logic [VW-1:0] rep(input int v);
    logic [VW-1:0] r;
    for (int i = 0; i < VS; i++) r[i*DW +: DW] = DW'(v);
    return r;
  endfunction

  function automatic logic [VW-1:0] lanes(input int l0, input int l1, input int l2,
                                          input int l3, input int l4, input int l5);
    return {DW'(l5), DW'(l4), DW'(l3), DW'(l2), DW'(l1), DW'(l0)};
  endfunction

  task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drv(input logic [2:0] op, input logic [VW-1:0] a, input logic [VW-1:0] b,
                     input int s, input logic us, input logic [VS-1:0] m, input logic sat);
    aluControl    = op;
    operand1      = a;
    operand2      = b;
    scalarOperand = DW'(s);
    useScalar     = us;
    vectorMask    = m;
    saturate      = sat;
    inValid       = 1'b1;
  endtask

  // Issue one op, confirm S2 is still empty after the accept edge, then step to the result cycle.
  task automatic single(input string tag, input logic [2:0] op, input logic [VW-1:0] a,
                        input logic [VW-1:0] b, input int s, input logic us,
                        input logic [VS-1:0] m, input logic sat);
    drv(op, a, b, s, us, m, sat);
    tick();
    inValid = 1'b0;
    chk({tag, "_lat"}, VW'(outValid), VW'(1'b0));
    tick();
    chk({tag, "_valid"}, VW'(outValid), VW'(1'b1));
  endtask

  int  next_op, nrx;
  logic acc;

  initial begin
    reset = 1'b0; inValid = 1'b0; outReady = 1'b1;
    aluControl = '0; operand1 = '0; operand2 = '0; scalarOperand = '0;
    useScalar = 1'b0; vectorMask = '0; saturate = 1'b0;
    #12;
    chk("rst_outvalid", VW'(outValid), VW'(1'b0));
    chk("rst_result", result, '0);
    chk("rst_cmp_ovf", VW'({compareMask, overflow}), '0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rst_inready", VW'(inReady), VW'(1'b1));
    @(negedge clock);

    single("add", OP_ADD, rep(2048), rep(1024), 0, 1'b0, 6'h3F, 1'b0);
    chk("add_res", result, rep(3072));
    chk("add_ovf", VW'(overflow), '0);

    single("mul_a", OP_MUL, rep(3072), rep(77), 4096, 1'b1, 6'h3F, 1'b0);
    chk("mul_a_res", result, rep(6144));
    chk("mul_a_ovf", VW'(overflow), '0);
    single("mul_b", OP_MUL, rep(-2048), '0, 2048, 1'b1, 6'h3F, 1'b0);
    chk("mul_b_res", result, rep(-2048));
    single("mul_floor", OP_MUL, rep(-1), '0, 1, 1'b1, 6'h3F, 1'b0);
    chk("mul_floor_res", result, rep(-1));
    single("mul_ovf", OP_MUL, rep(131072), '0, 131072, 1'b1, 6'h3F, 1'b1);
    chk("mul_ovf_res", result, rep(262143));
    chk("mul_ovf_flag", VW'(overflow), VW'(6'h3F));

    single("sat1", OP_ADD, rep(262143), rep(1), 0, 1'b0, 6'h3F, 1'b1);
    chk("sat1_res", result, rep(262143));
    chk("sat1_ovf", VW'(overflow), VW'(6'h3F));
    single("sat0", OP_ADD, rep(262143), rep(1), 0, 1'b0, 6'h3F, 1'b0);
    chk("sat0_res", result, rep(-262144));
    chk("sat0_ovf", VW'(overflow), VW'(6'h3F));
    single("subsat", OP_SUB, rep(-262144), rep(1), 0, 1'b0, 6'h3F, 1'b1);
    chk("subsat_res", result, rep(-262144));

    single("cmp", OP_LT, lanes(0, 1, 2, 3, 4, 5), rep(3), 0, 1'b0, 6'b101010, 1'b0);
    chk("cmp_mask", VW'(compareMask), VW'(6'b000010));
    chk("cmp_res", result, lanes(0, 1, 2, 3, 4, 5));
    single("cmp_signed", OP_LT, rep(-1), rep(3), 0, 1'b0, 6'h3F, 1'b0);
    chk("cmp_signed_mask", VW'(compareMask), VW'(6'h3F));
    single("madd", OP_ADD, lanes(0, 1, 2, 3, 4, 5), rep(10), 0, 1'b0, 6'b010101, 1'b0);
    chk("madd_res", result, lanes(10, 1, 12, 3, 14, 5));
    single("mask_ovf", OP_ADD, rep(262143), rep(1), 0, 1'b0, 6'b000011, 1'b0);
    chk("mask_ovf_flag", VW'(overflow), VW'(6'b000011));
    chk("mask_ovf_res", result, lanes(-262144, -262144, 262143, 262143, 262143, 262143));

    single("xor", OP_XOR, rep(5), rep(3), 0, 1'b0, 6'h3F, 1'b0);
    chk("xor_res", result, rep(6));
    single("and", OP_AND, rep(5), rep(3), 0, 1'b0, 6'h3F, 1'b0);
    chk("and_res", result, rep(1));
    single("or", OP_OR, rep(5), rep(3), 0, 1'b0, 6'h3F, 1'b0);
    chk("or_res", result, rep(7));
    single("pass", OP_PASS, rep(5), rep(3), 9, 1'b1, 6'h3F, 1'b0);
    chk("pass_res", result, rep(9));

    drv(OP_ADD, rep(1), rep(100), 0, 1'b0, 6'h3F, 1'b0);
    tick();
    drv(OP_ADD, rep(2), rep(100), 0, 1'b0, 6'h3F, 1'b0);
    tick();
    outReady = 1'b0;
    drv(OP_ADD, rep(999), rep(999), 0, 1'b0, 6'h3F, 1'b0);
    #1;
    chk("bb_first", result, rep(101));
    chk("bb_full_ready", VW'(inReady), VW'(1'b0));
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("bb_hold_res", result, rep(101));
      chk("bb_hold_valid", VW'(outValid), VW'(1'b1));
      chk("bb_hold_ready", VW'(inReady), VW'(1'b0));
    end
    outReady = 1'b1;
    #1;
    chk("bb_release_ready", VW'(inReady), VW'(1'b1));
    next_op = 3;
    nrx     = 0;
    for (int c = 0; c < 12; c++) begin
      if (outValid) begin
        if (nrx < 6) chk("bb_order", result, rep(101 + nrx));
        nrx++;
      end
      if (next_op <= 6) drv(OP_ADD, rep(next_op), rep(100), 0, 1'b0, 6'h3F, 1'b0);
      else inValid = 1'b0;
      #1;
      acc = inValid && inReady;
      tick();
      if (acc) next_op++;
    end
    chk("bb_count", VW'(nrx), VW'(6));

    drv(OP_ADD, rep(262143), rep(1), 0, 1'b0, 6'h3F, 1'b0);
    tick();
    drv(OP_ADD, rep(7), rep(8), 0, 1'b0, 6'h3F, 1'b0);
    tick();
    inValid = 1'b0;
    chk("rf_pre_valid", VW'(outValid), VW'(1'b1));
    chk("rf_pre_ovf", VW'(overflow), VW'(6'h3F));
    #1 reset = 1'b0;
    #1;
    chk("rf_valid", VW'(outValid), VW'(1'b0));
    chk("rf_result", result, '0);
    chk("rf_ovf", VW'(overflow), '0);
    @(posedge clock);
    #2 reset = 1'b1;
    @(negedge clock);
    nrx = 0;
    for (int c = 0; c < 4; c++) begin
      if (outValid) nrx++;
      tick();
    end
    chk("rf_no_stale", VW'(nrx), '0);
    chk("rf_ready", VW'(inReady), VW'(1'b1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
